hazard_stall_ctrl: RTL

- Pipeline stall/flush controller for the RV32IM 5-stage core. It sits directly downstream of the load-use hazard unit and consumes its BUBBLE output.
- Merges three stall/flush sources into the per-stage enable/flush controls for PC, IF/ID, ID/EX and EX/MEM:
  - load-use bubble
  - EX-stage branch/jump redirect
  - multi-cycle MUL/DIV occupancy of EX
- Contains the FSM and wait counter for multi-cycle M-extension ops.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/muldiv_wait_counter.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline stall/flush controller
package hazard_pkg;

  typedef enum logic {
    RUN         = 1'b0,
    MULDIV_WAIT = 1'b1
  } state_t;

  localparam int DEF_MUL_CYCLES = 2;
  localparam int DEF_DIV_CYCLES = 33;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_bubble;
    logic muldiv_done;
  } ctrl_t;

  localparam ctrl_t CTL_DEFAULT = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_we: 1'b1,
                                    idex_flush: 1'b0, exmem_bubble: 1'b0, muldiv_done: 1'b0};
  localparam ctrl_t CTL_RESET   = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_we: 1'b0,
                                    idex_flush: 1'b1, exmem_bubble: 1'b1, muldiv_done: 1'b0};
  // Upstream frozen while the M-unit occupies EX; EX/MEM receives NOPs.
  localparam ctrl_t CTL_HOLD    = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_we: 1'b0,
                                    idex_flush: 1'b0, exmem_bubble: 1'b1, muldiv_done: 1'b0};

endpackage

// File: rtl/muldiv_wait_counter.sv
// rtl/muldiv_wait_counter.sv - remaining-cycle counter for multi-cycle M-extension ops
module muldiv_wait_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - merges load-use, redirect and MUL/DIV stalls into stage enables/flushes
// Optional HAZARD_PERF_CNT_EN adds three saturating 32-bit performance counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BUBBLE,
  input  logic        BRANCH_TAKEN,
  input  logic        MULDIV_REQ,
  input  logic        MULDIV_IS_DIV,
  output logic        PC_WRITE_EN,
  output logic        IFID_WRITE_EN,
  output logic        IFID_FLUSH,
  output logic        IDEX_WRITE_EN,
  output logic        IDEX_FLUSH,
  output logic        EXMEM_BUBBLE,
  output logic        MULDIV_DONE,
  output logic [31:0] LOAD_STALL_CNT,
  output logic [31:0] MULDIV_STALL_CNT,
  output logic [31:0] FLUSH_CNT
);

  localparam bit MUL_STALLS = (MUL_CYCLES >= 2);
  localparam bit DIV_STALLS = (DIV_CYCLES >= 2);
  localparam logic [CNT_W-1:0] MUL_LOAD = MUL_STALLS ? CNT_W'(MUL_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD = DIV_STALLS ? CNT_W'(DIV_CYCLES - 2) : '0;

  state_t           state, state_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt;
  logic             req_stalls;
  ctrl_t            ctl;

  assign req_stalls = MULDIV_IS_DIV ? DIV_STALLS : MUL_STALLS;

  muldiv_wait_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      RUN: begin
        if (!BRANCH_TAKEN && !BUBBLE && MULDIV_REQ && req_stalls) begin
          state_nxt    = MULDIV_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = MULDIV_IS_DIV ? DIV_LOAD : MUL_LOAD;
        end
      end
      MULDIV_WAIT: begin
        if (cnt_zero) begin
          state_nxt = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Redirect beats load-use beats M-op; a single-cycle M-op completes without stalling.
  always_comb begin
    ctl = CTL_DEFAULT;
    if (!RESET) begin
      ctl = CTL_RESET;
    end else begin
      case (state)
        RUN: begin
          if (BRANCH_TAKEN) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
          end else if (BUBBLE) begin
            ctl.pc_we      = 1'b0;
            ctl.ifid_we    = 1'b0;
            ctl.idex_flush = 1'b1;
          end else if (MULDIV_REQ) begin
            if (req_stalls) begin
              ctl = CTL_HOLD;
            end else begin
              ctl.muldiv_done = 1'b1;
            end
          end
        end
        MULDIV_WAIT: begin
          if (cnt_zero) begin
            ctl.muldiv_done = 1'b1;
          end else begin
            ctl = CTL_HOLD;
          end
        end
        default: ctl = CTL_DEFAULT;
      endcase
    end
  end

  assign PC_WRITE_EN   = ctl.pc_we;
  assign IFID_WRITE_EN = ctl.ifid_we;
  assign IFID_FLUSH    = ctl.ifid_flush;
  assign IDEX_WRITE_EN = ctl.idex_we;
  assign IDEX_FLUSH    = ctl.idex_flush;
  assign EXMEM_BUBBLE  = ctl.exmem_bubble;
  assign MULDIV_DONE   = ctl.muldiv_done;

`ifdef HAZARD_PERF_CNT_EN
  logic ev_flush, ev_load;
  logic [31:0] load_cnt_q, mstall_cnt_q, flush_cnt_q;

  assign ev_flush = (state == RUN) && BRANCH_TAKEN;
  assign ev_load  = (state == RUN) && !BRANCH_TAKEN && BUBBLE;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      load_cnt_q   <= '0;
      mstall_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (ev_load && (load_cnt_q != '1))             load_cnt_q   <= load_cnt_q + 1'b1;
      if (ctl.exmem_bubble && (mstall_cnt_q != '1))  mstall_cnt_q <= mstall_cnt_q + 1'b1;
      if (ev_flush && (flush_cnt_q != '1))           flush_cnt_q  <= flush_cnt_q + 1'b1;
    end
  end

  assign LOAD_STALL_CNT   = load_cnt_q;
  assign MULDIV_STALL_CNT = mstall_cnt_q;
  assign FLUSH_CNT        = flush_cnt_q;
`else
  assign LOAD_STALL_CNT   = '0;
  assign MULDIV_STALL_CNT = '0;
  assign FLUSH_CNT        = '0;
`endif

endmodule
